// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder cell, LSB first, WIDTH cycles per op.
// Optional SERIAL_ADDSUB_SAT_EN clamps overflowed results to the signed limit.
module serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_shift;
  logic             r_mode;
  logic             r_carry;
  logic [IW-1:0]    r_idx;

  logic             w_bb;
  logic             w_sum;
  logic             w_cnext;
  logic             w_last;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;

  // Operands shift right so bit i sits at position 0 on step i; sum bits enter the
  // shift register at the MSB so bit i lands at position i after the final step.
  assign w_bb    = r_b[0] ^ r_mode;
  assign w_sum   = r_a[0] ^ w_bb ^ r_carry;
  assign w_cnext = (r_a[0] & w_bb) | ((r_a[0] ^ w_bb) & r_carry);
  assign w_last  = (r_idx == IW'(WIDTH - 1));
  // On the last step r_carry is the carry into the MSB, so ovf is formed on that edge.
  assign w_ovf   = r_carry ^ w_cnext;
  assign busy    = (r_state == RUN);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_res = {w_sum, r_shift[WIDTH-1:1]};
`ifdef SERIAL_ADDSUB_SAT_EN
    if (w_ovf) begin
      w_res = w_cnext ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_shift <= '0;
      r_mode  <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_mode  <= mode;
            r_carry <= mode;
            r_idx   <= '0;
            r_shift <= '0;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_cnext;
          r_idx   <= r_idx + 1'b1;
          r_shift <= {w_sum, r_shift[WIDTH-1:1]};
          if (w_last) begin
            result <= w_res;
            cout   <= w_cnext;
            ovf    <= w_ovf;
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: a posedge acceptance model pushes expected results,
// a negedge monitor checks busy/done timing, result stability and completion values.
module tb_serial_addsub;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] result;

  serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    int unsigned  done_edge;
  } exp_t;

  exp_t         q[$];
  int unsigned  cyc = 0;
  int unsigned  model_done_edge = 0;
  logic [W-1:0] last_res = '0;
  logic         last_c = 1'b0;
  logic         last_v = 1'b0;
  int           checks = 0;
  int           errors = 0;

  function automatic exp_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                 input logic fm, input int unsigned edge_n);
    exp_t e;
    int ua, ub, sa, sb, ur, sr;
    ua = int'(fa);
    ub = int'(fb);
    sa = fa[W-1] ? ua - (1 << W) : ua;
    sb = fb[W-1] ? ub - (1 << W) : ub;
    if (fm) begin
      ur  = ua - ub;
      sr  = sa - sb;
      e.c = (ua >= ub);
    end else begin
      ur  = ua + ub;
      sr  = sa + sb;
      e.c = (ur >= (1 << W));
    end
    e.res = W'(ur);
    e.v   = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
`ifdef SERIAL_ADDSUB_SAT_EN
    if (e.v) e.res = (sr > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
    e.done_edge = edge_n + W;
    return e;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  // Acceptance model: a request is taken whenever the previous op has completed.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      q.delete();
      model_done_edge = 0;
      last_res = '0;
      last_c   = 1'b0;
      last_v   = 1'b0;
    end else if (start && cyc > model_done_edge) begin
      q.push_back(model(a, b, mode, cyc));
      model_done_edge = cyc + W;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_busy, exp_done;
      exp_busy = (q.size() > 0) && (cyc < q[0].done_edge);
      exp_done = (q.size() > 0) && (cyc == q[0].done_edge);
      chk("busy", int'(busy), int'(exp_busy));
      chk("done", int'(done), int'(exp_done));
      if (exp_done) begin
        exp_t e;
        e = q.pop_front();
        last_res = e.res;
        last_c   = e.c;
        last_v   = e.v;
      end
      if (done || exp_done) begin
        chk("result", int'(result), int'(last_res));
        chk("cout", int'(cout), int'(last_c));
        chk("ovf", int'(ovf), int'(last_v));
      end else if (busy) begin
        chk("result_hold", int'(result), int'(last_res));
      end
    end
  end

  task automatic wait_idle();
    @(negedge clk);
    while (cyc < model_done_edge) @(negedge clk);
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic im);
    wait_idle();
    a = ia; b = ib; mode = im; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int unsigned first_done;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_cout", int'(cout), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst_n = 1'b1;

    issue(8'h25, 8'h1A, 1'b0);
    issue(8'h10, 8'h01, 1'b1);
    issue(8'h00, 8'h01, 1'b1);
    issue(8'h7F, 8'h01, 1'b0);
    issue(8'h80, 8'h01, 1'b1);
    issue(8'hFF, 8'h01, 1'b0);
    // Second start pulse while busy must be ignored.
    @(negedge clk);
    a = 8'h33; b = 8'h44; mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Held start: second op accepted on the edge after the done edge.
    wait_idle();
    a = 8'h12; b = 8'h34; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    first_done = model_done_edge;
    a = 8'hC8; b = 8'h5A; mode = 1'b1;
    while (cyc < first_done + 1) @(negedge clk);
    start = 1'b0;

    // Asynchronous reset in the middle of a run.
    issue(8'h55, 8'h2B, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_result", int'(result), 0);
    chk("arst_cout", int'(cout), 0);
    chk("arst_ovf", int'(ovf), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(8'h9C, 8'h64, 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(3) == 0) begin
        wait_idle();
        a = ra; b = rb; mode = 1'($urandom); start = 1'b1;
        repeat (W + 1) @(negedge clk);
        start = 1'b0;
      end else begin
        issue(ra, rb, 1'($urandom));
      end
    end

    for (int n = 0; n < 100 && q.size() > 0; n++) @(negedge clk);
    if (q.size() > 0) chk("drain", q.size(), 0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
